// File: rtl/core_inst_queue_pkg.sv
// core_inst_queue_pkg: shared widths and helpers for the fetch-to-decode instruction queue.
package core_inst_queue_pkg;
  localparam int INST_W = 32;
  localparam int PC_W = 32;
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction
endpackage

// File: rtl/core_inst_queue_ram.sv
// core_inst_queue_ram: entry array with two write ports and two async read ports.
module core_inst_queue_ram #(
  parameter int DEPTH = 8,
  parameter int W = 96
) (
  input  logic                     clk,
  input  logic [1:0]               we,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [W-1:0]             wdata0,
  input  logic [W-1:0]             wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [W-1:0]             rdata0,
  output logic [W-1:0]             rdata1
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr0] <= wdata0;
    if (we[1]) mem[waddr1] <= wdata1;
  end
  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
endmodule

// File: rtl/core_inst_queue.sv
// core_inst_queue: two-in/two-out decoupling queue between fetch F2 and decode.
// Valid fetch slots are compacted in program order; ready_o depends on registered count only.
module core_inst_queue
  import core_inst_queue_pkg::*;
#(
  parameter int ATTACHED_INFO_WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          valid_i,
  input  logic [1:0][INST_W-1:0]              inst_i,
  input  logic [PC_W-1:0]                     pc_i,
  input  logic [ATTACHED_INFO_WIDTH-1:0]      attached_i,
  output logic                                ready_o,
  output logic [1:0]                          valid_o,
  output logic [1:0][INST_W-1:0]              inst_o,
  output logic [1:0][PC_W-1:0]                pc_o,
  output logic [1:0][ATTACHED_INFO_WIDTH-1:0] attached_o,
  input  logic [1:0]                          ready_i,
  input  logic                                flush_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = INST_W + PC_W + ATTACHED_INFO_WIDTH;
  logic [PW-1:0] rptr, wptr, count;
  logic [1:0] push_v, push_n, pop_n;
  logic [EW-1:0] e0, e1, r0, r1;
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc_i[2:0];
  assign count = wptr - rptr;
  assign ready_o = count <= PW'(DEPTH - 2);
  assign valid_o = {count >= PW'(2), count != '0};
  assign push_v = valid_i & {2{ready_o}};
  assign push_n = popcount2(push_v);
  assign pop_n = popcount2({valid_o[1] & ready_i[0] & ready_i[1], valid_o[0] & ready_i[0]});
  // A lone slot 1 is compacted down onto the wptr write port.
  assign e1 = {inst_i[1], pc_i[31:3], 3'b100, attached_i};
  assign e0 = push_v[0] ? {inst_i[0], pc_i[31:3], 3'b000, attached_i} : e1;
  core_inst_queue_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    ({push_n == 2'd2, push_n != 2'd0}),
    .waddr0(wptr[AW-1:0]),
    .waddr1(wptr[AW-1:0] + AW'(1)),
    .wdata0(e0),
    .wdata1(e1),
    .raddr0(rptr[AW-1:0]),
    .raddr1(rptr[AW-1:0] + AW'(1)),
    .rdata0(r0),
    .rdata1(r1)
  );
  assign {inst_o[0], pc_o[0], attached_o[0]} = r0;
  assign {inst_o[1], pc_o[1], attached_o[1]} = r1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      wptr <= wptr + PW'(push_n);
      rptr <= rptr + PW'(pop_n);
    end
  end
  // Fetch must hold its group while the queue is not ready; such data is dropped.
  a_no_push_when_not_ready: assert property (@(posedge clk) disable iff (!rst_n) !(|valid_i && !ready_o));
endmodule

// File: tb/tb_core_inst_queue.sv
// tb_core_inst_queue: directed and random stimulus checked against a queue-based reference model.
module tb_core_inst_queue;
  localparam int AIW = 32;
  localparam int DEPTH = 8;
  typedef struct packed {
    logic [31:0]    inst;
    logic [31:0]    pc;
    logic [AIW-1:0] att;
  } ent_t;
  logic clk = 0, rst_n = 0, ready_o, flush_i = 0;
  logic [1:0] valid_i = 0, valid_o, ready_i = 0;
  logic [1:0][31:0] inst_i = '0, inst_o, pc_o;
  logic [31:0] pc_i = 0;
  logic [AIW-1:0] attached_i = 0;
  logic [1:0][AIW-1:0] attached_o;
  ent_t q[$];
  int nchk = 0, nerr = 0;
  logic [31:0] pc = 0;

  core_inst_queue #(.ATTACHED_INFO_WIDTH(AIW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .inst_i(inst_i), .pc_i(pc_i),
    .attached_i(attached_i), .ready_o(ready_o), .valid_o(valid_o), .inst_o(inst_o),
    .pc_o(pc_o), .attached_o(attached_o), .ready_i(ready_i), .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ready_o", 64'(ready_o), 64'(q.size() <= DEPTH - 2));
    chk("valid_o", 64'(valid_o), {62'd0, q.size() >= 2, q.size() >= 1});
    for (int k = 0; k < 2; k++)
      if (q.size() > k) begin
        chk($sformatf("inst_o[%0d]", k), 64'(inst_o[k]), 64'(q[k].inst));
        chk($sformatf("pc_o[%0d]", k), 64'(pc_o[k]), 64'(q[k].pc));
        chk($sformatf("attached_o[%0d]", k), 64'(attached_o[k]), 64'(q[k].att));
      end
  endtask

  // One clock: check current outputs, drive a group (dropped by F2 stall if not ready), advance the model.
  task automatic cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p, input logic [1:0] r, input logic f);
    logic [AIW-1:0] a;
    int npop;
    a = $urandom;
    check_outputs();
    if (q.size() > DEPTH - 2) v = 2'b00;
    valid_i = v; inst_i[0] = i0; inst_i[1] = i1; pc_i = p; attached_i = a; ready_i = r; flush_i = f;
    @(posedge clk);
    if (f) q.delete();
    else begin
      npop = 0;
      if (r[0] && q.size() >= 1) npop = (r[1] && q.size() >= 2) ? 2 : 1;
      repeat (npop) void'(q.pop_front());
      if (v[0]) q.push_back('{i0, {p[31:3], 3'b000}, a});
      if (v[1]) q.push_back('{i1, {p[31:3], 3'b100}, a});
    end
    #1;
  endtask

  task automatic idle(input logic [1:0] r);
    cycle(2'b00, 0, 0, 0, r, 1'b0);
  endtask

  initial begin
    #12 rst_n = 1;
    @(posedge clk); #1;
    // basic push: fill-to-output latency of one cycle
    idle(2'b00);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    cycle(2'b11, 32'hAAAA0001, 32'hAAAA0002, 32'h1C000000, 2'b00, 1'b0);
    chk("t1_valid", 64'(valid_o), 64'd3);
    chk("t1_pc0", 64'(pc_o[0]), 64'h1C000000);
    chk("t1_pc1", 64'(pc_o[1]), 64'h1C000004);
    idle(2'b11);
    // compaction of a slot-1-only group
    cycle(2'b10, 32'h0, 32'hBBBB0002, 32'h1C000008, 2'b00, 1'b0);
    cycle(2'b11, 32'hCCCC0001, 32'hCCCC0002, 32'h1C000010, 2'b00, 1'b0);
    chk("t2_pc0", 64'(pc_o[0]), 64'h1C00000C);
    chk("t2_inst0", 64'(inst_o[0]), 64'hBBBB0002);
    chk("t2_pc1", 64'(pc_o[1]), 64'h1C000010);
    idle(2'b01);
    chk("t2_pc0b", 64'(pc_o[0]), 64'h1C000010);
    chk("t2_pc1b", 64'(pc_o[1]), 64'h1C000014);
    idle(2'b11);
    idle(2'b00);
    chk("t2_empty", 64'(valid_o), 64'd0);
    // fill to full with decode stalled, then release
    pc = 32'h2000_0000;
    for (int i = 0; i < 5; i++) begin
      cycle(2'b11, $urandom, $urandom, pc, 2'b00, 1'b0);
      pc += 8;
    end
    chk("t3_full_ready", 64'(ready_o), 64'd0);
    idle(2'b11);
    chk("t3_ready_back", 64'(ready_o), 64'd1);
    // steady state across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cycle(2'b11, $urandom, $urandom, pc, 2'b11, 1'b0);
      pc += 8;
    end
    chk("t4_count_kept", 64'(q.size()), 64'd6);
    // partial pops at count 3
    cycle(2'b00, 0, 0, 0, 2'b00, 1'b1);
    cycle(2'b11, $urandom, $urandom, 32'h3000_0000, 2'b00, 1'b0);
    cycle(2'b01, $urandom, $urandom, 32'h3000_0008, 2'b00, 1'b0);
    idle(2'b01);
    chk("t5_pc0_after_one", 64'(pc_o[0]), 64'h3000_0004);
    idle(2'b10);
    chk("t5_pc0_after_none", 64'(pc_o[0]), 64'h3000_0004);
    // flush wins over same-cycle push and pop at count 5
    cycle(2'b11, $urandom, $urandom, 32'h3000_0010, 2'b00, 1'b0);
    cycle(2'b01, $urandom, $urandom, 32'h3000_0018, 2'b00, 1'b0);
    cycle(2'b11, $urandom, $urandom, 32'h3000_0020, 2'b11, 1'b1);
    chk("t6_flush_valid", 64'(valid_o), 64'd0);
    chk("t6_flush_ready", 64'(ready_o), 64'd1);
    // async reset mid-cycle
    cycle(2'b11, $urandom, $urandom, 32'h4000_0000, 2'b00, 1'b0);
    valid_i = 0; ready_i = 0;
    #3 rst_n = 0;
    #1 chk("t6_async_valid", 64'(valid_o), 64'd0);
    chk("t6_async_ready", 64'(ready_o), 64'd1);
    q.delete();
    #1 rst_n = 1;
    @(posedge clk); #1;
    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(2'($urandom), $urandom, $urandom, $urandom, 2'($urandom), $urandom_range(0, 31) == 0);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
